// File: rtl/rvfi_order_sequencer_if.sv
// Bundle of the RVFI retirement inputs and the in-order output channel of rvfi_order_sequencer.
// master drives retirements in and observes the ordered stream; slave is the sequencer.
interface rvfi_order_sequencer_if #(
  parameter int NRET    = 2,
  parameter int ORDER_W = 8,
  parameter int DEPTH   = 16,
  parameter int PW      = 128
);
  logic [NRET-1:0]         in_valid;
  logic [NRET*ORDER_W-1:0] in_order;
  logic [NRET*PW-1:0]      in_payload;
  logic                    out_valid;
  logic [ORDER_W-1:0]      out_order;
  logic [PW-1:0]           out_payload;
  logic [ORDER_W-1:0]      next_order;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    err_dup;
  logic                    err_window;
  logic                    err_gap;

  modport master (
    output in_valid, in_order, in_payload,
    input  out_valid, out_order, out_payload, next_order, occupancy,
           err_dup, err_window, err_gap
  );

  modport slave (
    input  in_valid, in_order, in_payload,
    output out_valid, out_order, out_payload, next_order, occupancy,
           err_dup, err_window, err_gap
  );
endinterface

// File: rtl/rvfi_order_sequencer.sv
// Reorders up to NRET retirements per cycle by order field and re-emits them one per cycle in order.
// Optional head-gap timeout is enabled by defining RISCV_FORMAL_SEQ_GAP_TIMEOUT_EN.
module rvfi_order_sequencer #(
  parameter int NRET    = 2,
  parameter int ORDER_W = 8,
  parameter int DEPTH   = 16,
  parameter int PW      = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  rvfi_order_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]   r_occ_vec;
  logic [PW-1:0]      r_data [DEPTH];
  logic [ORDER_W-1:0] r_next_order;
  logic               r_out_valid;
  logic [ORDER_W-1:0] r_out_order;
  logic [PW-1:0]      r_out_payload;
  logic [OCC_W-1:0]   r_occupancy;
  logic               r_err_dup;
  logic               r_err_window;

  logic [ORDER_W-1:0] w_order [NRET];
  logic [ORDER_W-1:0] w_dist  [NRET];
  logic [IDX_W-1:0]   w_slot  [NRET];
  logic [NRET-1:0]    w_in_win;
  logic [NRET-1:0]    w_accept;
  logic [NRET-1:0]    w_dup_hit;
  logic [NRET-1:0]    w_win_hit;
  logic [DEPTH-1:0]   w_occ_next;
  logic [IDX_W-1:0]   w_head_slot;
  logic               w_drain;
  logic [OCC_W-1:0]   w_accept_cnt;
  logic [OCC_W-1:0]   w_occupancy_next;

  assign w_head_slot = r_next_order[IDX_W-1:0];
  assign w_drain     = r_occ_vec[w_head_slot];

  generate
    for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
      logic w_same_lower;

      assign w_order[gi]  = bus.in_order[gi*ORDER_W +: ORDER_W];
      assign w_dist[gi]   = w_order[gi] - r_next_order;
      assign w_in_win[gi] = ({1'b0, w_dist[gi]} < (ORDER_W+1)'(DEPTH));
      assign w_slot[gi]   = w_order[gi][IDX_W-1:0];

      // The lowest-numbered channel wins when several carry the same order.
      always_comb begin
        w_same_lower = 1'b0;
        for (int k = 0; k < gi; k++) begin
          if (bus.in_valid[k] && (w_order[k] == w_order[gi])) w_same_lower = 1'b1;
        end
      end

      assign w_win_hit[gi] = bus.in_valid[gi] && !w_in_win[gi];
      assign w_dup_hit[gi] = bus.in_valid[gi] && w_in_win[gi] &&
                             (r_occ_vec[w_slot[gi]] || w_same_lower);
      assign w_accept[gi]  = bus.in_valid[gi] && w_in_win[gi] &&
                             !r_occ_vec[w_slot[gi]] && !w_same_lower;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic w_set;

      always_comb begin
        w_set = 1'b0;
        for (int c = 0; c < NRET; c++) begin
          if (w_accept[c] && (w_slot[c] == IDX_W'(gi))) w_set = 1'b1;
        end
      end

      // A write can never target the slot being drained, so set and clear are disjoint.
      assign w_occ_next[gi] = (r_occ_vec[gi] || w_set) &&
                              !(w_drain && (w_head_slot == IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    w_accept_cnt = '0;
    for (int c = 0; c < NRET; c++) w_accept_cnt = w_accept_cnt + OCC_W'(w_accept[c]);
    w_occupancy_next = r_occupancy + w_accept_cnt - OCC_W'(w_drain);
  end

  // Payload storage carries no reset; validity lives in r_occ_vec.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NRET; c++) begin
      if (w_accept[c]) r_data[w_slot[c]] <= bus.in_payload[c*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_occ_vec     <= '0;
      r_next_order  <= '0;
      r_out_valid   <= 1'b0;
      r_out_order   <= '0;
      r_out_payload <= '0;
      r_occupancy   <= '0;
      r_err_dup     <= 1'b0;
      r_err_window  <= 1'b0;
    end else begin
      r_occ_vec   <= w_occ_next;
      r_occupancy <= w_occupancy_next;
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_out_order   <= r_next_order;
        r_out_payload <= r_data[w_head_slot];
        r_next_order  <= r_next_order + 1'b1;
      end
      if (|w_dup_hit) r_err_dup    <= 1'b1;
      if (|w_win_hit) r_err_window <= 1'b1;
    end
  end

`ifdef RISCV_FORMAL_SEQ_GAP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] w_gap_cnt_next;
  logic             r_err_gap;

  always_comb begin
    w_gap_cnt_next = '0;
    if ((r_occupancy != '0) && !w_drain) begin
      w_gap_cnt_next = (r_gap_cnt == CNT_W'(TIMEOUT)) ? r_gap_cnt : r_gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gap_cnt <= '0;
      r_err_gap <= 1'b0;
    end else begin
      r_gap_cnt <= w_gap_cnt_next;
      if (w_gap_cnt_next == CNT_W'(TIMEOUT)) r_err_gap <= 1'b1;
    end
  end

  assign bus.err_gap = r_err_gap;
`else
  // TIMEOUT is non-negative, so this is constant 0 without the gap timeout.
  assign bus.err_gap = (TIMEOUT < 0);
`endif

  assign bus.out_valid   = r_out_valid;
  assign bus.out_order   = r_out_order;
  assign bus.out_payload = r_out_payload;
  assign bus.next_order  = r_next_order;
  assign bus.occupancy   = r_occupancy;
  assign bus.err_dup     = r_err_dup;
  assign bus.err_window  = r_err_window;
endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Directed self-checking bench for rvfi_order_sequencer; gap checks follow RISCV_FORMAL_SEQ_GAP_TIMEOUT_EN.
module tb_rvfi_order_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rvfi_order_sequencer_if #(.NRET(2), .ORDER_W(8), .DEPTH(16), .PW(128)) bus ();

  rvfi_order_sequencer #(.NRET(2), .ORDER_W(8), .DEPTH(16), .PW(128), .TIMEOUT(64)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [127:0] pay(input logic [7:0] o);
    return {8{o, o ^ 8'h5A}};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                       input logic [127:0] p0, input logic [127:0] p1);
    bus.in_valid   = v;
    bus.in_order   = {o1, o0};
    bus.in_payload = {p1, p0};
  endtask

  task automatic idle();
    drive(2'b00, 8'h00, 8'h00, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_order !== 8'd0 || bus.out_payload !== 128'd0) begin
      errors++;
      $display("FAIL reset_out got v=%0b o=%0d p=%h want 0", bus.out_valid, bus.out_order, bus.out_payload);
    end
    checks++;
    if (bus.next_order !== 8'd0 || bus.occupancy !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got next=%0d occ=%0d want 0/0", bus.next_order, bus.occupancy);
    end
    checks++;
    if ({bus.err_dup, bus.err_window, bus.err_gap} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err got %b want 000", {bus.err_dup, bus.err_window, bus.err_gap});
    end
    resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_in_order();
    logic exp_v;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) drive(2'b01, 8'(k), 8'd0, pay(8'(k)), '0);
      else idle();
      tick();
      exp_v = (k >= 1 && k <= 4);
      checks++;
      if (bus.out_valid !== exp_v) begin
        errors++;
        $display("FAIL inorder_valid k=%0d got %0b want %0b", k, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bus.out_order !== 8'(k - 1) || bus.out_payload !== pay(8'(k - 1))) begin
          errors++;
          $display("FAIL inorder_data k=%0d got o=%0d want o=%0d", k, bus.out_order, k - 1);
        end
      end
    end
    checks++;
    if (bus.next_order !== 8'd4 || bus.occupancy !== 5'd0 || bus.err_dup !== 1'b0 || bus.err_window !== 1'b0) begin
      errors++;
      $display("FAIL inorder_end got next=%0d occ=%0d dup=%0b win=%0b want 4/0/0/0",
               bus.next_order, bus.occupancy, bus.err_dup, bus.err_window);
    end
    $display("test_in_order done");
  endtask

  task automatic test_swap();
    do_reset();
    drive(2'b11, 8'd1, 8'd0, 128'hAAAA, 128'hBBBB);
    tick();
    idle();
    checks++;
    if (bus.occupancy !== 5'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL swap_fill got occ=%0d v=%0b want 2/0", bus.occupancy, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_order !== 8'd0 || bus.out_payload !== 128'hBBBB || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL swap_first got v=%0b o=%0d p=%h occ=%0d want 1/0/bbbb/1",
               bus.out_valid, bus.out_order, bus.out_payload, bus.occupancy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_order !== 8'd1 || bus.out_payload !== 128'hAAAA || bus.occupancy !== 5'd0) begin
      errors++;
      $display("FAIL swap_second got v=%0b o=%0d p=%h occ=%0d want 1/1/aaaa/0",
               bus.out_valid, bus.out_order, bus.out_payload, bus.occupancy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_dup !== 1'b0 || bus.err_window !== 1'b0) begin
      errors++;
      $display("FAIL swap_idle got v=%0b dup=%0b win=%0b want 0/0/0", bus.out_valid, bus.err_dup, bus.err_window);
    end
    $display("test_swap done");
  endtask

  task automatic test_wrap();
    logic exp_v;
    do_reset();
    for (int k = 0; k <= 302; k++) begin
      if (k <= 300) drive(2'b01, 8'(k), 8'd0, pay(8'(k)), '0);
      else idle();
      tick();
      exp_v = (k >= 1 && k <= 301);
      checks++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_order !== 8'(k - 1) || bus.out_payload !== pay(8'(k - 1))))) begin
        errors++;
        $display("FAIL wrap k=%0d got v=%0b o=%0d want v=%0b o=%0d", k, bus.out_valid, bus.out_order, exp_v, 8'(k - 1));
      end
    end
    checks++;
    if (bus.next_order !== 8'd45 || bus.err_dup !== 1'b0 || bus.err_window !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got next=%0d dup=%0b win=%0b want 45/0/0", bus.next_order, bus.err_dup, bus.err_window);
    end
    $display("test_wrap done");
  endtask

  task automatic test_window_dup();
    logic exp_v;
    do_reset();
    drive(2'b01, 8'd15, 8'd0, pay(8'd15), '0);
    tick();
    checks++;
    if (bus.err_window !== 1'b0 || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL window_edge got win=%0b occ=%0d want 0/1", bus.err_window, bus.occupancy);
    end
    drive(2'b01, 8'd16, 8'd0, pay(8'd16), '0);
    tick();
    checks++;
    if (bus.err_window !== 1'b1 || bus.occupancy !== 5'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL window_out got win=%0b occ=%0d v=%0b want 1/1/0", bus.err_window, bus.occupancy, bus.out_valid);
    end
    drive(2'b01, 8'd3, 8'd0, pay(8'd3), '0);
    tick();
    drive(2'b01, 8'd3, 8'd0, 128'hDEAD, '0);
    tick();
    checks++;
    if (bus.err_dup !== 1'b1 || bus.occupancy !== 5'd2) begin
      errors++;
      $display("FAIL dup_flag got dup=%0b occ=%0d want 1/2", bus.err_dup, bus.occupancy);
    end
    for (int k = 0; k <= 5; k++) begin
      if (k < 3) drive(2'b01, 8'(k), 8'd0, pay(8'(k)), '0);
      else idle();
      tick();
      exp_v = (k >= 1 && k <= 4);
      checks++;
      if (bus.out_valid !== exp_v || (exp_v && (bus.out_order !== 8'(k - 1) || bus.out_payload !== pay(8'(k - 1))))) begin
        errors++;
        $display("FAIL dup_drain k=%0d got v=%0b o=%0d want v=%0b o=%0d", k, bus.out_valid, bus.out_order, exp_v, k - 1);
      end
    end
    checks++;
    if (bus.next_order !== 8'd4 || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL dup_end got next=%0d occ=%0d want 4/1", bus.next_order, bus.occupancy);
    end
    $display("test_window_dup done");
  endtask

  task automatic test_same_cycle_dup();
    do_reset();
    drive(2'b11, 8'd0, 8'd0, 128'h1111, 128'h2222);
    tick();
    idle();
    checks++;
    if (bus.err_dup !== 1'b1 || bus.occupancy !== 5'd1) begin
      errors++;
      $display("FAIL samecyc_flag got dup=%0b occ=%0d want 1/1", bus.err_dup, bus.occupancy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_order !== 8'd0 || bus.out_payload !== 128'h1111) begin
      errors++;
      $display("FAIL samecyc_keep got v=%0b o=%0d p=%h want 1/0/1111", bus.out_valid, bus.out_order, bus.out_payload);
    end
    $display("test_same_cycle_dup done");
  endtask

  task automatic test_gap();
    logic exp_gap;
    do_reset();
    drive(2'b01, 8'd1, 8'd0, pay(8'd1), '0);
    tick();
    idle();
    for (int i = 1; i <= 70; i++) begin
      tick();
`ifdef RISCV_FORMAL_SEQ_GAP_TIMEOUT_EN
      exp_gap = (i >= 64);
`else
      exp_gap = 1'b0;
`endif
      if (i == 1 || i == 63 || i == 64 || i == 70) begin
        checks++;
        if (bus.err_gap !== exp_gap || bus.occupancy !== 5'd1 || bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap i=%0d got gap=%0b occ=%0d v=%0b want %0b/1/0", i, bus.err_gap, bus.occupancy, bus.out_valid, exp_gap);
        end
      end
    end
    $display("test_gap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(2'b11, 8'd2, 8'd3, pay(8'd2), pay(8'd3));
    tick();
    idle();
    checks++;
    if (bus.occupancy !== 5'd2) begin
      errors++;
      $display("FAIL midrst_fill got occ=%0d want 2", bus.occupancy);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.occupancy !== 5'd0 || bus.next_order !== 8'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got occ=%0d next=%0d v=%0b want 0/0/0", bus.occupancy, bus.next_order, bus.out_valid);
    end
    tick();
    resetn = 1'b1;
    drive(2'b01, 8'd0, 8'd0, pay(8'd0), '0);
    tick();
    idle();
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_order !== 8'd0 || bus.out_payload !== pay(8'd0)) begin
      errors++;
      $display("FAIL midrst_first got v=%0b o=%0d want 1/0", bus.out_valid, bus.out_order);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale i=%0d got v=%0b o=%0d want v=0", i, bus.out_valid, bus.out_order);
      end
    end
    checks++;
    if (bus.occupancy !== 5'd0 || bus.next_order !== 8'd1) begin
      errors++;
      $display("FAIL midrst_end got occ=%0d next=%0d want 0/1", bus.occupancy, bus.next_order);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    idle();
    test_reset();
    test_in_order();
    test_swap();
    test_wrap();
    test_window_dup();
    test_same_cycle_dup();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
